// File: rtl/ground_pkg.sv
// Shared constants and types for the scrolling ground strip and its
// random source.
package ground_pkg;

    localparam int TILE_W = 128;
    localparam int POS_W  = 10;
    localparam int SPAN   = 768;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 expressed as a mask over q[7:0].
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } scroll_state_t;

    function automatic logic [POS_W-1:0] init_pos(input int unsigned idx);
        return POS_W'(idx * TILE_W + TILE_W - 1);
    endfunction

endpackage

// File: rtl/ground_scroller_if.sv
// Control inputs and tile layout outputs shared between the scroller and
// the frame timing / ground renderer side.
interface ground_scroller_if #(parameter int N_TILES = 6);
    import ground_pkg::*;

    logic                     frame_tick;
    logic                     start;
    logic                     collide;
    logic [N_TILES*POS_W-1:0] tile_pos;
    logic [N_TILES-1:0]       tile_en;
    logic [3:0]               speed;
    logic [15:0]              distance;
    logic                     running;
    logic                     game_over;

    modport master (
        output frame_tick, start, collide,
        input  tile_pos, tile_en, speed, distance, running, game_over
    );

    modport slave (
        input  frame_tick, start, collide,
        output tile_pos, tile_en, speed, distance, running, game_over
    );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; reset loads the seed, advances every clock.
module lfsr8
    import ground_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= LFSR_SEED;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/ground_scroller.sv
// Ground tile sequencer: scrolls N_TILES tile positions each frame, wraps
// them with random pit placement, ramps speed and freezes on collision.
module ground_scroller
    import ground_pkg::*;
#(
    parameter int N_TILES     = 6,
    parameter int INIT_SPEED  = 2,
    parameter int MAX_SPEED   = 8,
    parameter int RAMP_FRAMES = 600,
    parameter int GRACE_WRAPS = 6
) (
    input  logic clk,
    input  logic reset,
    ground_scroller_if.slave bus
);

    localparam logic [10:0] SPAN_W     = 11'(N_TILES * TILE_W);
    localparam logic [3:0]  SPEED_INIT = 4'(INIT_SPEED);
    localparam logic [3:0]  SPEED_MAX  = 4'(MAX_SPEED);
    localparam logic [15:0] RAMP_LAST  = 16'(RAMP_FRAMES - 1);
    localparam logic [7:0]  GRACE_INIT = 8'(GRACE_WRAPS);

    scroll_state_t      state_q, state_d;
    logic [POS_W-1:0]   pos_q [N_TILES];
    logic [POS_W-1:0]   pos_d [N_TILES];
    logic [N_TILES-1:0] en_q, en_d;
    logic [3:0]         speed_q, speed_d;
    logic [15:0]        distance_q, distance_d;
    logic [15:0]        ramp_q, ramp_d;
    logic [7:0]         grace_q, grace_d;
    logic               last_gap_q, last_gap_d;
    logic               running_q, game_over_q;

    logic [7:0]         lfsr;
    logic [POS_W-1:0]   nxt_pos [N_TILES];
    logic [N_TILES-1:0] wrap;
    logic               init, step, force_solid, pit_roll, new_en;
    logic [16:0]        dist_sum;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    for (genvar g = 0; g < N_TILES; g++) begin : g_tile
        logic [10:0] p_ext;
        logic [10:0] s_ext;
        assign p_ext = {1'b0, pos_q[g]};
        assign s_ext = {7'b0, speed_q};
        assign wrap[g] = p_ext < s_ext;
        assign nxt_pos[g] = wrap[g] ? POS_W'(p_ext + SPAN_W - s_ext)
                                    : POS_W'(p_ext - s_ext);
        assign bus.tile_pos[g*POS_W +: POS_W] = pos_q[g];
    end

    // Speed stays below a tile width, so at most one wrap bit is set per step.
    assign force_solid = (grace_q != '0) || last_gap_q;
    assign pit_roll    = (lfsr & 8'h03) == 8'h03;
    assign new_en      = force_solid | ~pit_roll;
    assign dist_sum    = {1'b0, distance_q} + {13'b0, speed_q};

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        en_d       = en_q;
        speed_d    = speed_q;
        distance_d = distance_q;
        ramp_d     = ramp_q;
        grace_d    = grace_q;
        last_gap_d = last_gap_q;
        init       = 1'b0;
        step       = 1'b0;

        unique case (state_q)
            IDLE: if (bus.start) begin state_d = RUN; init = 1'b1; end
            RUN: begin
                if (bus.collide)         state_d = STOP;
                else if (bus.frame_tick) step = 1'b1;
            end
            STOP: if (bus.start) begin state_d = RUN; init = 1'b1; end
            default: state_d = IDLE;
        endcase

        if (init) begin
            for (int unsigned i = 0; i < N_TILES; i++) pos_d[i] = init_pos(i);
            en_d       = '1;
            speed_d    = SPEED_INIT;
            distance_d = '0;
            ramp_d     = '0;
            grace_d    = GRACE_INIT;
            last_gap_d = 1'b0;
        end

        if (step) begin
            for (int unsigned i = 0; i < N_TILES; i++) begin
                pos_d[i] = nxt_pos[i];
                if (wrap[i]) en_d[i] = new_en;
            end
            if (|wrap) begin
                if (grace_q != '0) grace_d = grace_q - 8'd1;
                last_gap_d = ~new_en;
            end
            distance_d = dist_sum[16] ? '1 : dist_sum[15:0];
            if (ramp_q == RAMP_LAST) begin
                ramp_d = '0;
                if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
            end else begin
                ramp_d = ramp_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int unsigned i = 0; i < N_TILES; i++) pos_q[i] <= init_pos(i);
            en_q        <= '1;
            speed_q     <= SPEED_INIT;
            distance_q  <= '0;
            ramp_q      <= '0;
            grace_q     <= GRACE_INIT;
            last_gap_q  <= 1'b0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            en_q        <= en_d;
            speed_q     <= speed_d;
            distance_q  <= distance_d;
            ramp_q      <= ramp_d;
            grace_q     <= grace_d;
            last_gap_q  <= last_gap_d;
            running_q   <= (state_d == RUN);
            game_over_q <= (state_d == STOP);
        end
    end

    assign bus.tile_en   = en_q;
    assign bus.speed     = speed_q;
    assign bus.distance  = distance_q;
    assign bus.running   = running_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_ground_scroller.sv
// Directed self-checking bench for ground_scroller: one default instance and
// one with a short ramp period.
module tb_ground_scroller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int errors = 0;
    int checks = 0;

    ground_scroller_if #(.N_TILES(6)) bus_a ();
    ground_scroller_if #(.N_TILES(6)) bus_b ();

    ground_scroller #(
        .N_TILES(6), .INIT_SPEED(2), .MAX_SPEED(8),
        .RAMP_FRAMES(600), .GRACE_WRAPS(6)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    ground_scroller #(
        .N_TILES(6), .INIT_SPEED(2), .MAX_SPEED(8),
        .RAMP_FRAMES(4), .GRACE_WRAPS(6)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    function automatic logic [9:0] pa(input int i);
        return bus_a.tile_pos[10*i +: 10];
    endfunction

    function automatic logic [9:0] pb(input int i);
        return bus_b.tile_pos[10*i +: 10];
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_a();
        bus_a.frame_tick = 1'b1;
        step_clk();
        bus_a.frame_tick = 1'b0;
        step_clk();
    endtask

    task automatic tick_b();
        bus_b.frame_tick = 1'b1;
        step_clk();
        bus_b.frame_tick = 1'b0;
        step_clk();
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        step_clk();
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (pa(i) !== 10'(128*i + 127)) begin
                errors++;
                $display("FAIL reset_pos[%0d] got=%0d exp=%0d", i, pa(i), 128*i + 127);
            end
        end
        checks++;
        if (bus_a.tile_en !== 6'h3F) begin
            errors++; $display("FAIL reset_en got=%h exp=3f", bus_a.tile_en);
        end
        checks++;
        if (bus_a.speed !== 4'd2) begin
            errors++; $display("FAIL reset_speed got=%0d exp=2", bus_a.speed);
        end
        checks++;
        if (bus_a.distance !== 16'd0) begin
            errors++; $display("FAIL reset_distance got=%0d exp=0", bus_a.distance);
        end
        checks++;
        if (bus_a.running !== 1'b0 || bus_a.game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got run=%b go=%b exp 0/0", bus_a.running, bus_a.game_over);
        end
        checks++;
        if (dut_a.u_lfsr.q !== 8'hA5) begin
            errors++; $display("FAIL reset_lfsr got=%h exp=a5", dut_a.u_lfsr.q);
        end
    endtask

    task automatic test_first_tick();
        bus_a.start = 1'b1;
        step_clk();
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.running !== 1'b1) begin
            errors++; $display("FAIL start_running got=%b exp=1", bus_a.running);
        end
        tick_a();
        checks++;
        if (pa(0) !== 10'd125 || pa(5) !== 10'd765) begin
            errors++; $display("FAIL first_tick_pos got p0=%0d p5=%0d exp 125/765", pa(0), pa(5));
        end
        checks++;
        if (bus_a.distance !== 16'd2 || bus_a.speed !== 4'd2) begin
            errors++;
            $display("FAIL first_tick_dist_speed got d=%0d s=%0d exp 2/2", bus_a.distance, bus_a.speed);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 62; k++) tick_a();
        checks++;
        if (pa(0) !== 10'd1) begin
            errors++; $display("FAIL pre_wrap_pos got=%0d exp=1", pa(0));
        end
        tick_a();
        checks++;
        if (pa(0) !== 10'd767 || bus_a.tile_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_tile0 got pos=%0d en=%b exp 767/1", pa(0), bus_a.tile_en[0]);
        end
        for (int i = 1; i < 6; i++) begin
            checks++;
            if (pa(i) !== 10'(128*i - 1)) begin
                errors++; $display("FAIL wrap_pos[%0d] got=%0d exp=%0d", i, pa(i), 128*i - 1);
            end
        end
        checks++;
        if (bus_a.distance !== 16'd128) begin
            errors++; $display("FAIL wrap_distance got=%0d exp=128", bus_a.distance);
        end
    endtask

    task automatic test_pits();
        int m_pos [6];
        int m_speed, m_ramp, m_dist, wraps, pits, n_wrap;
        logic [59:0] exp_vec;
        logic last_en, wrapped;
        for (int i = 0; i < 6; i++) m_pos[i] = (128*i + 127 + 768 - 128) % 768;
        m_speed = 2; m_ramp = 64; m_dist = 128;
        wraps = 0; pits = 0; last_en = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            tick_a();
            wrapped = 1'b0;
            n_wrap = 0;
            for (int i = 0; i < 6; i++) begin
                if (m_pos[i] >= m_speed) m_pos[i] = m_pos[i] - m_speed;
                else begin
                    m_pos[i] = m_pos[i] + 768 - m_speed;
                    wrapped = 1'b1;
                    n_wrap = i;
                end
                exp_vec[10*i +: 10] = 10'(m_pos[i]);
            end
            m_dist = m_dist + m_speed;
            if (m_ramp == 599) begin
                m_ramp = 0;
                if (m_speed < 8) m_speed++;
            end else m_ramp++;
            checks++;
            if (bus_a.tile_pos !== exp_vec || bus_a.speed !== 4'(m_speed)
                || bus_a.distance !== 16'(m_dist)) begin
                errors++;
                $display("FAIL scroll_step t=%0d got pos=%h s=%0d d=%0d exp pos=%h s=%0d d=%0d",
                         t, bus_a.tile_pos, bus_a.speed, bus_a.distance, exp_vec, m_speed, m_dist);
                break;
            end
            if (wrapped) begin
                wraps++;
                if (wraps <= 5) begin
                    checks++;
                    if (bus_a.tile_en[n_wrap] !== 1'b1) begin
                        errors++;
                        $display("FAIL grace_solid wrap=%0d got=%b exp=1", wraps, bus_a.tile_en[n_wrap]);
                    end
                end
                if (bus_a.tile_en[n_wrap] === 1'b0) begin
                    pits++;
                    checks++;
                    if (last_en === 1'b0) begin
                        errors++; $display("FAIL double_pit wrap=%0d got=0 exp=1", wraps);
                    end
                end
                last_en = bus_a.tile_en[n_wrap];
            end
        end
        checks++;
        if (pits < 2 || pits * 2 > wraps) begin
            errors++; $display("FAIL pit_rate got pits=%0d of wraps=%0d exp ~25%%", pits, wraps);
        end
    endtask

    task automatic test_collide();
        logic [59:0] snap_pos;
        logic [15:0] snap_dist;
        snap_pos  = bus_a.tile_pos;
        snap_dist = bus_a.distance;
        bus_a.collide    = 1'b1;
        bus_a.frame_tick = 1'b1;
        step_clk();
        bus_a.collide    = 1'b0;
        bus_a.frame_tick = 1'b0;
        checks++;
        if (bus_a.tile_pos !== snap_pos || bus_a.distance !== snap_dist) begin
            errors++;
            $display("FAIL collide_freeze got pos=%h d=%0d exp pos=%h d=%0d",
                     bus_a.tile_pos, bus_a.distance, snap_pos, snap_dist);
        end
        checks++;
        if (bus_a.game_over !== 1'b1 || bus_a.running !== 1'b0) begin
            errors++;
            $display("FAIL collide_flags got go=%b run=%b exp 1/0", bus_a.game_over, bus_a.running);
        end
        for (int k = 0; k < 3; k++) tick_a();
        bus_a.collide = 1'b1;
        step_clk();
        bus_a.collide = 1'b0;
        checks++;
        if (bus_a.tile_pos !== snap_pos || bus_a.distance !== snap_dist || bus_a.game_over !== 1'b1) begin
            errors++;
            $display("FAIL stop_frozen got pos=%h d=%0d go=%b exp pos=%h d=%0d go=1",
                     bus_a.tile_pos, bus_a.distance, bus_a.game_over, snap_pos, snap_dist);
        end
        bus_a.start = 1'b1;
        step_clk();
        bus_a.start = 1'b0;
        checks++;
        if (pa(0) !== 10'd127 || pa(5) !== 10'd767 || bus_a.distance !== 16'd0
            || bus_a.tile_en !== 6'h3F || bus_a.speed !== 4'd2) begin
            errors++;
            $display("FAIL restart_init got p0=%0d p5=%0d d=%0d en=%h s=%0d exp 127/767/0/3f/2",
                     pa(0), pa(5), bus_a.distance, bus_a.tile_en, bus_a.speed);
        end
        checks++;
        if (bus_a.running !== 1'b1 || bus_a.game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart_flags got run=%b go=%b exp 1/0", bus_a.running, bus_a.game_over);
        end
    endtask

    task automatic test_back_to_back();
        bus_a.start = 1'b1;
        for (int k = 0; k < 3; k++) tick_a();
        checks++;
        if (bus_a.distance !== 16'd6 || pa(0) !== 10'd121) begin
            errors++;
            $display("FAIL held_start got d=%0d p0=%0d exp 6/121", bus_a.distance, pa(0));
        end
        bus_a.collide = 1'b1;
        step_clk();
        bus_a.collide = 1'b0;
        checks++;
        if (bus_a.game_over !== 1'b1 || bus_a.running !== 1'b0 || bus_a.distance !== 16'd6) begin
            errors++;
            $display("FAIL start_collide got go=%b run=%b d=%0d exp 1/0/6",
                     bus_a.game_over, bus_a.running, bus_a.distance);
        end
        step_clk();
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.running !== 1'b1 || bus_a.distance !== 16'd0 || pa(0) !== 10'd127) begin
            errors++;
            $display("FAIL stop_restart got run=%b d=%0d p0=%0d exp 1/0/127",
                     bus_a.running, bus_a.distance, pa(0));
        end
    endtask

    task automatic test_ramp();
        int exp_s;
        bus_b.start = 1'b1;
        step_clk();
        bus_b.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick_b();
            exp_s = 2 + k / 4;
            if (exp_s > 8) exp_s = 8;
            checks++;
            if (bus_b.speed !== 4'(exp_s)) begin
                errors++;
                $display("FAIL ramp_speed tick=%0d got=%0d exp=%0d", k, bus_b.speed, exp_s);
            end
        end
    endtask

    task automatic test_reset_midrun();
        rst_b = 1'b1;
        step_clk();
        rst_b = 1'b0;
        bus_b.start = 1'b1;
        step_clk();
        bus_b.start = 1'b0;
        for (int k = 0; k < 12; k++) tick_b();
        checks++;
        if (bus_b.speed !== 4'd5 || bus_b.running !== 1'b1) begin
            errors++;
            $display("FAIL midrun_speed got s=%0d run=%b exp 5/1", bus_b.speed, bus_b.running);
        end
        rst_b = 1'b1;
        bus_b.frame_tick = 1'b1;
        bus_b.start = 1'b1;
        step_clk();
        rst_b = 1'b0;
        bus_b.frame_tick = 1'b0;
        bus_b.start = 1'b0;
        checks++;
        if (bus_b.running !== 1'b0 || bus_b.speed !== 4'd2 || bus_b.distance !== 16'd0
            || pb(0) !== 10'd127 || pb(3) !== 10'd511 || bus_b.tile_en !== 6'h3F) begin
            errors++;
            $display("FAIL midrun_reset got run=%b s=%0d d=%0d p0=%0d p3=%0d en=%h exp 0/2/0/127/511/3f",
                     bus_b.running, bus_b.speed, bus_b.distance, pb(0), pb(3), bus_b.tile_en);
        end
        checks++;
        if (dut_b.u_lfsr.q !== 8'hA5) begin
            errors++; $display("FAIL midrun_lfsr got=%h exp=a5", dut_b.u_lfsr.q);
        end
        bus_b.collide = 1'b1;
        bus_b.frame_tick = 1'b1;
        step_clk();
        bus_b.collide = 1'b0;
        bus_b.frame_tick = 1'b0;
        checks++;
        if (bus_b.game_over !== 1'b0 || bus_b.running !== 1'b0 || pb(0) !== 10'd127) begin
            errors++;
            $display("FAIL idle_ignore got go=%b run=%b p0=%0d exp 0/0/127",
                     bus_b.game_over, bus_b.running, pb(0));
        end
    endtask

    initial begin
        bus_a.frame_tick = 1'b0; bus_a.start = 1'b0; bus_a.collide = 1'b0;
        bus_b.frame_tick = 1'b0; bus_b.start = 1'b0; bus_b.collide = 1'b0;
        test_reset();
        test_first_tick();
        test_wrap();
        test_pits();
        test_collide();
        test_back_to_back();
        test_ramp();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ground_scroller.md
# ground_scroller

Sequencer for the scrolling ground strip. It owns the right-edge positions of `N_TILES` 128-px ground tiles and advances them by the current scroll speed once per video frame. It wraps each tile that leaves the left edge back to the right end, and on every wrap it randomly decides whether that tile becomes a pit. It also ramps speed over time, accumulates distance, and freezes everything on collision. It sits between the VGA timing generator (`frame_tick`) and the per-tile ground renderer instances, which take `tile_pos` slices as their `p` input.

## Interface
- `N_TILES`, 6, number of tiles; span = `N_TILES`*128 = 768 px
- `INIT_SPEED`, 2, px/frame after start
- `MAX_SPEED`, 8, speed ceiling; must be < 128
- `RAMP_FRAMES`, 600, frames between speed increments
- `GRACE_WRAPS`, 6, wraps after start that are forced solid
- `clk` in 1 system/pixel clock
- `reset` in 1 one clock; reset is synchronous and active-high
- `frame_tick` in 1 one-cycle pulse per frame (end of visible area)
- `start` in 1 level or pulse; begins/restarts a run
- `collide` in 1 goose-hit-obstacle flag from the collision logic
- `tile_pos` out `N_TILES`*10 tile i right edge at bits [10i+9:10i], range 0..767
- `tile_en` out `N_TILES` 1 = tile i solid ground, 0 = pit (do not draw, no isGround)
- `speed` out 4 current px/frame
- `distance` out 16 cumulative scrolled px, saturating
- `running` out 1 high in RUN
- `game_over` out 1 high in STOP

## Operation
- States are IDLE, RUN and STOP. Reset enters IDLE.
- IDLE: layout held at its initial value. `start` moves to RUN.
- RUN: `collide` moves to STOP. Otherwise, a `frame_tick` triggers one scroll step.
- STOP: all outputs frozen. `start` moves to RUN.
- Entering RUN, whether from IDLE or STOP, re-initialises everything:
  - `tile_pos[i]`=128i+127
  - `tile_en`=all 1
  - `speed`=`INIT_SPEED`
  - `distance`=0
  - ramp counter=0
  - grace counter=`GRACE_WRAPS`
  - last_gap=0
- Scroll step, per tile:
  - if `pos` >= `speed`, then `pos` -= `speed`
  - else `pos` = `pos` + 768 - `speed` (wrap)
  - Arithmetic is 11 bits internal; the result is always 0..767.
- Because `speed` < 128, at most one tile wraps per step.
- On a wrap, the new `tile_en` for that tile is chosen as follows:
  - If the grace counter > 0, or last_gap=1, the tile is forced to 1 and the grace counter decrements (not below 0).
  - Otherwise it is ~(lfsr[0] & lfsr[1]), i.e. a 25% pit chance.
  - last_gap takes the value ~new_en, so two pits never occur back to back.
- `distance` += `speed` each step, saturating at 16'hFFFF.
- Ramp: the counter increments each step. When it reaches `RAMP_FRAMES`-1 it clears, and `speed` increments, saturating at `MAX_SPEED`.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5.
  - Reset loads the seed. Re-entering RUN does not reseed.
  - Advances every clock in all states.
- `collide` is ignored in IDLE and STOP. `frame_tick` is ignored outside RUN.
- The renderer handles partial tiles (pos<127) with signed compare. That is not this block's concern.

## Timing
- All outputs are registered. Values after `reset`:
  - `tile_pos[i]`=128i+127
  - `tile_en`=all 1
  - `speed`=`INIT_SPEED`
  - `distance`=0
  - `running`=0
  - `game_over`=0
- `start` sampled at edge k gives `running`=1 and re-initialised values at k+1.
- `frame_tick` sampled at edge k gives new `tile_pos`, `tile_en`, `distance` and `speed` at k+1. A wrap and a ramp in the same step both apply.
- `collide` sampled at edge k gives `game_over`=1 at k+1. If `frame_tick` is also high at k, the step is not applied; the freeze wins.
- `start` and `collide` together in RUN: `collide` wins and the state goes to STOP.
- In STOP, `start` high restarts on the next edge. A held `start` does not re-trigger while in RUN.
- `reset` mid-run returns to IDLE on the next edge. Reset has priority over all inputs.
- `frame_tick` pulses separated by a single cycle are each handled; no pipelining hazard.

## Structure
- Package `ground_pkg` holds:
  - constants TILE_W=128, POS_W=10, SPAN=768
  - LFSR seed and tap mask
  - enum `scroll_state_t` {IDLE, RUN, STOP}
- Sub-module `lfsr8` (clk, reset, q[7:0]) provides the free-running random source, so it can be reused by the obstacle spawner.
- The per-tile update is a generate loop in the top module. The wrap-detect one-hot feeds the pit-decision logic.

## Test plan
- Reset, then `start`, then 1 `frame_tick`:
  - `tile_pos[0]`=125, `tile_pos[5]`=765, `distance`=2, `speed`=2.
- Wrap: run until `tile_pos[0]`=1, then tick at `speed` 2:
  - `tile_pos[0]`=767 and `tile_en[0]`=1 (grace).
  - Sum check: all positions stay distinct modulo 768.
- Pits: after grace expires, run 2000 ticks and log wraps:
  - roughly 25% pits, and never two consecutive wraps with `tile_en`=0.
- Ramp: `RAMP_FRAMES` set to 4 in the bench, run 40 ticks:
  - `speed` follows 2,3,…,8 and holds at 8.
- Collide together with `frame_tick` in the same cycle:
  - positions unchanged, `game_over`=1, `running`=0.
  - Further ticks give no change. `start` then re-initialises the layout with `distance`=0.
- `reset` asserted mid-run at `speed` 5:
  - next cycle IDLE, initial layout, `speed`=2, LFSR=8'hA5.
